// File: rtl/cpu_memif_mo.sv
// cpu_memif_mo: data-bus interface between execute (p3) and completion (p4).
// Keeps up to DEPTH bus transactions outstanding in an in-order table. Each
// cpud_ack retires the oldest entry. Read data is lane-extracted and then
// sign- or zero-extended.
// Optional feature: define CPU_MEMIF_TIMEOUT_EN to build the ack timeout.
// When enabled, a head entry that waits TIMEOUT_CYCLES without an ack is
// dropped and p4_bus_timeout pulses.
// Handshake: a request is taken on a rising edge where p3_request && !stall &&
// p3_ready. p3_ready is derived from registered occupancy only, so a pop in
// the same cycle does not make room for a push.
module cpu_memif_mo #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         stall,
  output logic                         cpud_request,
  output logic [ADDR_WIDTH-1:0]        cpud_addr,
  output logic                         cpud_write,
  output logic [3:0]                   cpud_byte_enable,
  output logic [31:0]                  cpud_wdata,
  input  logic [31:0]                  cpud_rdata,
  input  logic                         cpud_ack,
  input  logic                         p3_request,
  input  logic [ADDR_WIDTH-1:0]        p3_addr,
  input  logic                         p3_write,
  input  logic [3:0]                   p3_byte_enable,
  input  logic [31:0]                  p3_wdata,
  input  logic [1:0]                   p3_size,
  input  logic                         p3_unsigned,
  input  logic                         p3_misaligned_address,
  input  logic                         p3_access_deny,
  output logic                         p3_ready,
  output logic                         p4_write_pending,
  output logic                         p4_read_pending,
  output logic                         p4_misaligned_address,
  output logic                         p4_load_access_fault,
  output logic                         p4_store_access_fault,
  output logic                         p4_bus_timeout,
  output logic [31:0]                  p4_mem_rdata,
  output logic                         p4_mem_rdata_valid,
  output logic [ADDR_WIDTH-1:0]        p4_mem_addr,
  output logic [$clog2(DEPTH+1)-1:0]   p4_outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic                  write;
    logic [1:0]            size;
    logic [1:0]            lo;
    logic                  uns;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  entry_t          tbl_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, wr_cnt_q, rd_cnt_q;
  entry_t          head_e;
  logic            accept, fault, push, ack_pop, tmo_pop, pop;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     ext_data;

  assign head_e   = tbl_q[head_q];
  assign p3_ready = (count_q != CW'(DEPTH));
  assign accept   = p3_request && !stall && p3_ready;
  assign fault    = p3_misaligned_address || p3_access_deny;
  assign push     = accept && !fault;
  assign ack_pop  = cpud_ack && (count_q != '0);
  assign pop      = ack_pop || tmo_pop;

  assign p4_outstanding  = count_q;
  assign p4_read_pending = (rd_cnt_q != '0);
  // The last write retiring drops the flag in the ack cycle itself.
  assign p4_write_pending = (wr_cnt_q != '0) &&
                            !((wr_cnt_q == CW'(1)) && pop && head_e.write);

`ifdef CPU_MEMIF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tmo_cnt_q;

  assign tmo_pop = (count_q != '0) && !cpud_ack &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES-1));

  // Counts cycles the head has waited; restarts on every ack or drop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else if (cpud_ack || tmo_pop || (count_q == '0)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  // Never true: without the timeout feature the head waits indefinitely.
  assign tmo_pop = (TIMEOUT_CYCLES < 0);
`endif

  // Lane extraction and extension of the head read's data.
  always_comb begin
    byte_v   = 8'h00;
    half_v   = 16'h0000;
    ext_data = 32'h0;
    case (head_e.lo)
      2'd0:    byte_v = cpud_rdata[7:0];
      2'd1:    byte_v = cpud_rdata[15:8];
      2'd2:    byte_v = cpud_rdata[23:16];
      default: byte_v = cpud_rdata[31:24];
    endcase
    half_v = head_e.lo[1] ? cpud_rdata[31:16] : cpud_rdata[15:0];
    case (head_e.size)
      2'b00:   ext_data = {{24{byte_v[7] & ~head_e.uns}}, byte_v};
      2'b01:   ext_data = {{16{half_v[15] & ~head_e.uns}}, half_v};
      default: ext_data = cpud_rdata;
    endcase
  end

  // Table storage; pointers and occupancy give validity, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      tbl_q[tail_q] <= '{write: p3_write, size: p3_size, lo: p3_addr[1:0],
                         uns: p3_unsigned, addr: p3_addr};
    end
  end

  // Bus issue, table bookkeeping and registered p4 results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpud_request          <= 1'b0;
      cpud_addr             <= '0;
      cpud_write            <= 1'b0;
      cpud_byte_enable      <= 4'h0;
      cpud_wdata            <= 32'h0;
      head_q                <= '0;
      tail_q                <= '0;
      count_q               <= '0;
      wr_cnt_q              <= '0;
      rd_cnt_q              <= '0;
      p4_misaligned_address <= 1'b0;
      p4_load_access_fault  <= 1'b0;
      p4_store_access_fault <= 1'b0;
      p4_bus_timeout        <= 1'b0;
      p4_mem_rdata          <= 32'h0;
      p4_mem_rdata_valid    <= 1'b0;
      p4_mem_addr           <= '0;
    end else begin
      cpud_request <= push;
      if (push) begin
        cpud_addr        <= p3_addr;
        cpud_write       <= p3_write;
        cpud_byte_enable <= p3_byte_enable;
        cpud_wdata       <= p3_wdata;
        tail_q           <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      case ({push && p3_write, pop && head_e.write})
        2'b10:   wr_cnt_q <= wr_cnt_q + 1'b1;
        2'b01:   wr_cnt_q <= wr_cnt_q - 1'b1;
        default: wr_cnt_q <= wr_cnt_q;
      endcase
      case ({push && !p3_write, pop && !head_e.write})
        2'b10:   rd_cnt_q <= rd_cnt_q + 1'b1;
        2'b01:   rd_cnt_q <= rd_cnt_q - 1'b1;
        default: rd_cnt_q <= rd_cnt_q;
      endcase
      p4_misaligned_address <= accept && p3_misaligned_address;
      p4_load_access_fault  <= accept && p3_access_deny && !p3_write;
      p4_store_access_fault <= accept && p3_access_deny && p3_write;
      p4_bus_timeout        <= tmo_pop;
      p4_mem_rdata_valid    <= ack_pop && !head_e.write;
      if (ack_pop && !head_e.write) begin
        p4_mem_rdata <= ext_data;
      end
      // A timeout reports the dropped entry's address in place of the last request.
      if (tmo_pop) begin
        p4_mem_addr <= head_e.addr;
      end else if (accept) begin
        p4_mem_addr <= p3_addr;
      end
    end
  end

endmodule
